// File: rtl/mem_arbiter.sv
// mem_arbiter: N-client round-robin block arbiter in front of the single
// memory_controller. One transaction is in flight at a time. Each client sees
// one-cycle gnt / valid / err pulses. A BUSY watchdog aborts a transaction
// that the controller never completes.
module mem_arbiter #(
    parameter int NCLIENTS = 2,
    parameter int ADDRW    = 64,
    parameter int BLOCKSZ  = 512,
    parameter int TIMEOUT  = 1024,
    parameter int OFFW     = $clog2(BLOCKSZ / 8),
    parameter int IDW      = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NCLIENTS-1:0]         cli_req,
    input  logic [NCLIENTS-1:0]         cli_wr,
    input  logic [NCLIENTS*ADDRW-1:0]   cli_addr,
    input  logic [NCLIENTS*BLOCKSZ-1:0] cli_wdata,
    output logic [NCLIENTS-1:0]         cli_gnt,
    output logic [NCLIENTS-1:0]         cli_valid,
    output logic [NCLIENTS-1:0]         cli_err,
    output logic [BLOCKSZ-1:0]          cli_rdata,
    output logic                        mem_start,
    output logic [ADDRW-1:0]            mem_addr,
    output logic                        mem_wr,
    output logic [BLOCKSZ-1:0]          mem_wdata,
    input  logic [BLOCKSZ-1:0]          mem_rdata,
    input  logic                        mem_valid,
    output logic                        busy,
    output logic [IDW-1:0]              owner
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int             TW        = $clog2(TIMEOUT);
    localparam logic [TW-1:0]  TIMER_END = TW'(TIMEOUT - 1);
    localparam logic [ADDRW-1:0] ADDR_MASK = {ADDRW{1'b1}} << OFFW;

    logic [1:0]          state;
    logic [TW-1:0]       timer;
    // Client that completed/aborted last; the round-robin scan starts just above it.
    logic [IDW-1:0]      rr_last;
    // One-hot of the client just served, blocking its stale request for one IDLE cycle.
    logic [NCLIENTS-1:0] mask;

    logic [NCLIENTS-1:0] eligible;
    logic                any_eligible;
    logic [IDW-1:0]      sel;
    logic [ADDRW-1:0]    addr_arr  [NCLIENTS];
    logic [BLOCKSZ-1:0]  wdata_arr [NCLIENTS];

    function automatic logic [NCLIENTS-1:0] onehot(input logic [IDW-1:0] idx);
        logic [NCLIENTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Unflatten the per-client address and write-data buses.
    always_comb begin
        for (int i = 0; i < NCLIENTS; i++) begin
            addr_arr[i]  = cli_addr[i*ADDRW +: ADDRW];
            wdata_arr[i] = cli_wdata[i*BLOCKSZ +: BLOCKSZ];
        end
    end

    // Round-robin pick: first unmasked requester scanning upward from rr_last+1.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves
        // a value unassigned and no latch is inferred.
        eligible     = cli_req & ~mask;
        any_eligible = 1'b0;
        sel          = '0;
        for (int i = 0; i < NCLIENTS; i++) begin
            logic [IDW-1:0] idx;
            idx = IDW'((int'(rr_last) + 1 + i) % NCLIENTS);
            if (!any_eligible && eligible[idx]) begin
                any_eligible = 1'b1;
                sel          = idx;
            end
        end
    end

    // Control FSM plus all registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state     <= S_IDLE;
            timer     <= '0;
            rr_last   <= IDW'(NCLIENTS - 1);
            mask      <= '0;
            cli_gnt   <= '0;
            cli_valid <= '0;
            cli_err   <= '0;
            cli_rdata <= '0;
            mem_start <= 1'b0;
            mem_addr  <= '0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            owner     <= '0;
        end else begin
            // Handshake outputs are single-cycle pulses unless re-asserted below.
            mem_start <= 1'b0;
            cli_gnt   <= '0;
            cli_valid <= '0;
            cli_err   <= '0;

            case (state)
                S_IDLE: begin
                    mask <= '0;
                    if (any_eligible) begin
                        state     <= S_BUSY;
                        timer     <= '0;
                        busy      <= 1'b1;
                        owner     <= sel;
                        cli_gnt   <= onehot(sel);
                        mem_start <= 1'b1;
                        mem_addr  <= addr_arr[sel] & ADDR_MASK;
                        mem_wr    <= cli_wr[sel];
                        mem_wdata <= wdata_arr[sel];
                    end
                end

                S_BUSY: begin
                    timer <= timer + 1'b1;
                    if (mem_valid) begin
                        // Completion beats the watchdog when both land together.
                        state     <= S_DONE;
                        cli_rdata <= mem_rdata;
                        cli_valid <= onehot(owner);
                    end else if (timer == TIMER_END) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        cli_err <= onehot(owner);
                        mask    <= onehot(owner);
                        rr_last <= owner;
                    end
                end

                S_DONE: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    mask    <= onehot(owner);
                    rr_last <= owner;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (2 clients, 64-bit address, 512-bit
// blocks, watchdog shortened to 16 cycles). Inputs are driven and outputs
// sampled 1 ns after each rising edge.
module tb_mem_arbiter;

    localparam int NC = 2;
    localparam int AW = 64;
    localparam int BS = 512;
    localparam int TO = 16;
    localparam int IW = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC-1:0]     cli_req, cli_wr, cli_gnt, cli_valid, cli_err;
    logic [NC*AW-1:0]  cli_addr;
    logic [NC*BS-1:0]  cli_wdata;
    logic [BS-1:0]     cli_rdata, mem_wdata, mem_rdata;
    logic              mem_start, mem_wr, mem_valid, busy;
    logic [AW-1:0]     mem_addr;
    logic [IW-1:0]     owner;

    int n_tests = 0;
    int n_fail  = 0;

    logic [BS-1:0] wpat;
    logic [BS-1:0] rd_last;
    int            bad;

    mem_arbiter #(
        .NCLIENTS(NC), .ADDRW(AW), .BLOCKSZ(BS), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .cli_req(cli_req), .cli_wr(cli_wr), .cli_addr(cli_addr), .cli_wdata(cli_wdata),
        .cli_gnt(cli_gnt), .cli_valid(cli_valid), .cli_err(cli_err), .cli_rdata(cli_rdata),
        .mem_start(mem_start), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   512'(cli_gnt),   512'(0));
        check({tag, "_valid"}, 512'(cli_valid), 512'(0));
        check({tag, "_err"},   512'(cli_err),   512'(0));
        check({tag, "_rdata"}, cli_rdata,       512'(0));
        check({tag, "_start"}, 512'(mem_start), 512'(0));
        check({tag, "_addr"},  512'(mem_addr),  512'(0));
        check({tag, "_wr"},    512'(mem_wr),    512'(0));
        check({tag, "_wdata"}, mem_wdata,       512'(0));
        check({tag, "_busy"},  512'(busy),      512'(0));
        check({tag, "_owner"}, 512'(owner),     512'(0));
    endtask

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset     = 1'b1;
        cli_req   = '0;
        cli_wr    = '0;
        cli_addr  = '0;
        cli_wdata = '0;
        mem_rdata = '0;
        mem_valid = 1'b0;
        wpat      = {4{128'h00112233445566778899AABBCCDDEEFF}};
        rd_last   = '0;
        tick();
        tick();
        check_all_zero("rst");
        reset = 1'b0;

        // ---- Client 0 read, unaligned address, response after 5 cycles ----
        cli_req            = 2'b01;
        cli_wr             = 2'b00;
        cli_addr[0 +: AW]  = 64'h0000_0000_1000_0027;
        tick();
        check("t1_start", 512'(mem_start), 512'(1));
        check("t1_gnt",   512'(cli_gnt),   512'(2'b01));
        check("t1_addr",  512'(mem_addr),  512'(64'h1000_0000));
        check("t1_wr",    512'(mem_wr),    512'(0));
        check("t1_owner", 512'(owner),     512'(0));
        check("t1_busy",  512'(busy),      512'(1));
        // Dropping req and changing the address after the grant has no effect.
        cli_req           = 2'b00;
        cli_addr[0 +: AW] = 64'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) tick();
        check("t1_start_pulse", 512'(mem_start), 512'(0));
        check("t1_addr_held",   512'(mem_addr),  512'(64'h1000_0000));
        check("t1_no_valid",    512'(cli_valid), 512'(0));
        mem_valid = 1'b1;
        mem_rdata = {64{8'hA5}};
        tick();
        mem_valid = 1'b0;
        mem_rdata = '0;
        check("t1_valid", 512'(cli_valid), 512'(2'b01));
        check("t1_rdata", cli_rdata,       {64{8'hA5}});
        check("t1_busy_done", 512'(busy),  512'(1));
        tick();
        check("t1_valid_pulse", 512'(cli_valid), 512'(0));
        check("t1_idle_busy",   512'(busy),      512'(0));
        check("t1_rdata_keep",  cli_rdata,       {64{8'hA5}});
        tick();
        tick();

        // ---- Client 1 write block; inputs changed after grant are ignored ----
        cli_wdata[BS +: BS] = wpat;
        cli_wdata[0 +: BS]  = ~wpat;
        cli_addr[AW +: AW]  = 64'h2040;
        cli_wr              = 2'b10;
        cli_req             = 2'b10;
        tick();
        check("t3_gnt",   512'(cli_gnt),  512'(2'b10));
        check("t3_owner", 512'(owner),    512'(1));
        check("t3_wr",    512'(mem_wr),   512'(1));
        check("t3_addr",  512'(mem_addr), 512'(64'h2040));
        check("t3_wdata", mem_wdata,      wpat);
        cli_wdata[BS +: BS] = '0;
        cli_wr              = 2'b00;
        cli_addr[AW +: AW]  = 64'hFFFF;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_wdata !== wpat || mem_wr !== 1'b1 || mem_addr !== 64'h2040) bad++;
        end
        check("t3_hold", 512'(bad), 512'(0));
        mem_valid = 1'b1;
        mem_rdata = {64{8'h3C}};
        tick();
        mem_valid = 1'b0;
        cli_req   = 2'b00;
        check("t3_valid",      512'(cli_valid), 512'(2'b10));
        check("t3_rdata",      cli_rdata,       {64{8'h3C}});
        check("t3_wdata_keep", mem_wdata,       wpat);
        tick();
        tick();
        tick();

        // ---- From reset, both clients hold req: grants alternate 0,1,0,1 ----
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        cli_req = 2'b11;
        cli_wr  = 2'b00;
        tick();
        for (int k = 0; k < 4; k++) begin
            // Grant lands two cycles after the previous valid (DONE, then one IDLE).
            check($sformatf("t2_gnt%0d", k), 512'(cli_gnt), 512'(2'b01 << (k % 2)));
            tick();
            mem_valid = 1'b1;
            mem_rdata = {16{32'h1000_0000 + k}};
            rd_last   = {16{32'h1000_0000 + k}};
            tick();
            mem_valid = 1'b0;
            check($sformatf("t2_valid%0d", k), 512'(cli_valid), 512'(2'b01 << (k % 2)));
            if (k == 3) cli_req = 2'b00;
            tick();
            check($sformatf("t2_gap%0d", k), 512'(cli_gnt), 512'(0));
            tick();
        end
        check("t2_idle", 512'(cli_gnt), 512'(0));

        // ---- Watchdog: client 0 read with no response ----
        cli_req           = 2'b01;
        cli_addr[0 +: AW] = 64'h3000;
        tick();
        check("t4_gnt", 512'(cli_gnt), 512'(2'b01));
        cli_req = 2'b00;
        bad = 0;
        for (int j = 1; j < TO; j++) begin
            tick();
            if (cli_err !== 2'b00 || cli_valid !== 2'b00 || busy !== 1'b1) bad++;
        end
        check("t4_no_early", 512'(bad), 512'(0));
        tick();
        check("t4_err",      512'(cli_err),   512'(2'b01));
        check("t4_no_valid", 512'(cli_valid), 512'(0));
        check("t4_busy",     512'(busy),      512'(0));
        for (int i = 0; i < 4; i++) tick();
        mem_valid = 1'b1;
        mem_rdata = {64{8'hEE}};
        tick();
        mem_valid = 1'b0;
        check("t4_late_valid", 512'(cli_valid), 512'(0));
        check("t4_late_err",   512'(cli_err),   512'(0));
        check("t4_late_rdata", cli_rdata,       rd_last);
        check("t4_late_start", 512'(mem_start), 512'(0));

        // ---- Reset two cycles into client 1 BUSY; client 0 wins afterwards ----
        cli_req = 2'b10;
        tick();
        check("t5_gnt1", 512'(cli_gnt), 512'(2'b10));
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_all_zero("t5_rst");
        reset   = 1'b0;
        cli_req = 2'b11;
        tick();
        check("t5_prio",  512'(cli_gnt), 512'(2'b01));
        check("t5_owner", 512'(owner),   512'(0));
        tick();
        mem_valid = 1'b1;
        mem_rdata = {64{8'h77}};
        tick();
        mem_valid = 1'b0;
        cli_req   = 2'b00;
        check("t5_valid", 512'(cli_valid), 512'(2'b01));
        tick();
        tick();
        tick();

        // ---- Sole client holds req; then valid coincides with terminal count ----
        cli_req = 2'b01;
        tick();
        check("t6_gnt", 512'(cli_gnt), 512'(2'b01));
        tick();
        mem_valid = 1'b1;
        mem_rdata = {64{8'h11}};
        tick();
        mem_valid = 1'b0;
        check("t6_valid", 512'(cli_valid), 512'(2'b01));
        tick();
        check("t6_masked", 512'(cli_gnt), 512'(0));
        tick();
        check("t6_arb", 512'(cli_gnt), 512'(0));
        tick();
        check("t6_regnt",  512'(cli_gnt),   512'(2'b01));
        check("t6_start2", 512'(mem_start), 512'(1));
        bad = 0;
        for (int j = 1; j < TO; j++) begin
            tick();
            if (cli_err !== 2'b00 || cli_valid !== 2'b00) bad++;
        end
        check("t6_no_early", 512'(bad), 512'(0));
        mem_valid = 1'b1;
        mem_rdata = {64{8'h5A}};
        tick();
        mem_valid = 1'b0;
        cli_req   = 2'b00;
        check("t6_tc_valid", 512'(cli_valid), 512'(2'b01));
        check("t6_tc_err",   512'(cli_err),   512'(0));
        check("t6_tc_rdata", cli_rdata,       {64{8'h5A}});
        tick();
        check("t6_after_err",   512'(cli_err),   512'(0));
        check("t6_after_valid", 512'(cli_valid), 512'(0));
        check("t6_after_busy",  512'(busy),      512'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
